// File: rtl/spart_wr_responder_if.sv
// CPU store bus plus TX byte stream and program-switch handshake of the SPART write responder.
interface spart_wr_responder_if #(
    parameter int CNT_W = 4
);
    logic             spart_wrt_en;
    logic [31:0]      spart_wrt_add;
    logic [31:0]      spart_wrt_data;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             switch_program;
    logic [31:0]      SPART_pc;
    logic             ovf_err;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output spart_wrt_en, spart_wrt_add, spart_wrt_data, tx_ready,
        input  tx_data, tx_valid, switch_program, SPART_pc, ovf_err, fifo_count
    );

    modport slave (
        input  spart_wrt_en, spart_wrt_add, spart_wrt_data, tx_ready,
        output tx_data, tx_valid, switch_program, SPART_pc, ovf_err, fifo_count
    );
endinterface

// File: rtl/spart_wr_responder.sv
// Decodes CPU stores into a TX byte FIFO and a program-switch request that waits for the FIFO to drain.
// state | meaning
// IDLE  | no switch pending
// DRAIN | switch latched in pend_pc, waiting for the TX FIFO to empty
// FIRE  | one-cycle switch_program pulse, SPART_pc already updated
module spart_wr_responder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    spart_wr_responder_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, FIRE} state_t;

    state_t           state, state_next;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      pend_pc, spart_pc_q;
    logic             ovf_q;

    logic wr_tx, wr_sw, wr_ctrl, flush, clr_err;
    logic full, pop, push, drop;
    logic load_pend, load_pc, sw_err, fire;

    assign wr_tx   = bus.spart_wrt_en && (bus.spart_wrt_add == 32'h0000_0000);
    assign wr_sw   = bus.spart_wrt_en && (bus.spart_wrt_add == 32'h0000_0004);
    assign wr_ctrl = bus.spart_wrt_en && (bus.spart_wrt_add == 32'h0000_0008);
    assign flush   = wr_ctrl && bus.spart_wrt_data[1];
    assign clr_err = wr_ctrl && bus.spart_wrt_data[0];

    // Pop is judged on the registered count so tx_ready never reaches an output combinationally.
    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign pop  = (count != '0) && bus.tx_ready && !flush;
    assign push = wr_tx && (!full || pop);
    assign drop = wr_tx && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= bus.spart_wrt_data[7:0];
    end

    assign bus.tx_data    = mem[rd_ptr];
    assign bus.tx_valid   = (count != '0);
    assign bus.fifo_count = count;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_pend  = 1'b0;
        load_pc    = 1'b0;
        sw_err     = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (wr_sw) begin
                    load_pend  = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                sw_err = wr_sw;
                if ((count == '0) && !wr_tx) begin
                    load_pc    = 1'b1;
                    state_next = FIRE;
                end
            end
            FIRE: begin
                sw_err     = wr_sw;
                fire       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // SPART_pc loads on the edge entering FIRE so it is valid the whole time switch_program is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_pc    <= '0;
            spart_pc_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (load_pend) pend_pc <= bus.spart_wrt_data;
            if (load_pc)   spart_pc_q <= pend_pc;
            if (drop || sw_err) ovf_q <= 1'b1;
            else if (clr_err)   ovf_q <= 1'b0;
        end
    end

    assign bus.switch_program = fire;
    assign bus.SPART_pc       = spart_pc_q;
    assign bus.ovf_err        = ovf_q;
endmodule

// File: tb/tb_spart_wr_responder.sv
// Directed bench with a byte scoreboard and a reference model of the switch sequencer.
module tb_spart_wr_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spart_wr_responder_if bus ();
    spart_wr_responder dut (.clk(clk), .rst(rst), .bus(bus));

    localparam int M_IDLE = 0, M_DRAIN = 1, M_FIRE = 2;

    int          passed = 0;
    int          total  = 0;
    logic [7:0]  q[$];
    int          mst    = M_IDLE;
    logic [31:0] mpend  = 0;
    logic [31:0] mpc    = 0;
    logic        merr   = 0;
    int          pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare outputs against the model mid-cycle, then advance the model by this cycle's inputs.
    task automatic tick();
        logic wtx, wsw, flush, clr, err, pop, full, drain_ok;
        @(negedge clk);
        chk("tx_valid", 32'(bus.tx_valid), 32'(q.size() != 0));
        chk("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
        chk("ovf_err", 32'(bus.ovf_err), 32'(merr));
        chk("switch_program", 32'(bus.switch_program), 32'(mst == M_FIRE));
        chk("SPART_pc", bus.SPART_pc, mpc);
        if (q.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(q[0]));
        if (rst) begin
            q.delete();
            mst = M_IDLE; mpend = 0; mpc = 0; merr = 0;
        end else begin
            wtx   = bus.spart_wrt_en && bus.spart_wrt_add == 32'h0;
            wsw   = bus.spart_wrt_en && bus.spart_wrt_add == 32'h4;
            flush = bus.spart_wrt_en && bus.spart_wrt_add == 32'h8 && bus.spart_wrt_data[1];
            clr   = bus.spart_wrt_en && bus.spart_wrt_add == 32'h8 && bus.spart_wrt_data[0];
            err   = 1'b0;
            drain_ok = (q.size() == 0) && !wtx;
            if (flush) q.delete();
            else begin
                pop  = (q.size() != 0) && bus.tx_ready;
                full = (q.size() == 8);
                if (wtx && full && !pop) err = 1'b1;
                if (pop) void'(q.pop_front());
                if (wtx && !(full && !pop)) q.push_back(bus.spart_wrt_data[7:0]);
            end
            case (mst)
                M_IDLE:  if (wsw) begin mpend = bus.spart_wrt_data; mst = M_DRAIN; end
                M_DRAIN: begin
                    if (wsw) err = 1'b1;
                    if (drain_ok) begin mpc = mpend; mst = M_FIRE; end
                end
                default: begin
                    if (wsw) err = 1'b1;
                    mst = M_IDLE;
                end
            endcase
            if (err) merr = 1'b1;
            else if (clr) merr = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.spart_wrt_en   = 1'b1;
        bus.spart_wrt_add  = addr;
        bus.spart_wrt_data = data;
        tick();
        bus.spart_wrt_en   = 1'b0;
        bus.spart_wrt_add  = 32'hFFFF_FFF0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bus.spart_wrt_en   = 1'b0;
        bus.spart_wrt_add  = 32'hFFFF_FFF0;
        bus.spart_wrt_data = 32'h0;
        bus.tx_ready       = 1'b0;
        idle(2);
        rst = 1'b0;
        chk("reset fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("reset tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("reset SPART_pc", bus.SPART_pc, 32'h0);

        // In-order streaming with the serializer always ready
        bus.tx_ready = 1'b1;
        wr(32'h0, 32'hAAAA_AA41);
        wr(32'h0, 32'h0000_0042);
        wr(32'h0, 32'h0000_0043);
        idle(4);
        chk("stream drained", 32'(bus.fifo_count), 32'd0);

        // Overflow drops the ninth byte; CTRL bit0 clears the error
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr(32'h0, 32'(i));
        chk("full count", 32'(bus.fifo_count), 32'd8);
        chk("overflow flagged", 32'(bus.ovf_err), 32'd1);
        wr(32'hC, 32'h0000_0001);
        bus.tx_ready = 1'b1;
        idle(10);
        chk("unmapped write keeps error", 32'(bus.ovf_err), 32'd1);
        wr(32'h8, 32'h0000_0001);
        idle(1);
        chk("error cleared", 32'(bus.ovf_err), 32'd0);

        // Push into a full FIFO with a same-cycle pop, then wrap the pointers
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(32'h0, 32'h10 + 32'(i));
        bus.tx_ready = 1'b1;
        wr(32'h0, 32'h55);
        chk("full with pop count", 32'(bus.fifo_count), 32'd8);
        chk("full with pop no error", 32'(bus.ovf_err), 32'd0);
        for (int i = 0; i < 20; i++) begin
            bus.tx_ready = (i % 3) != 0;
            wr(32'h0, 32'h60 + 32'(i));
        end
        bus.tx_ready = 1'b1;
        idle(12);

        // Switch held off until the queued bytes drain
        bus.tx_ready = 1'b0;
        wr(32'h0, 32'hA1);
        wr(32'h0, 32'hA2);
        wr(32'h0, 32'hA3);
        wr(32'h4, 32'h0000_0100);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.switch_program) pulses++;
        end
        chk("no pulse while blocked", 32'(pulses), 32'd0);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.switch_program) pulses++;
        end
        chk("one pulse after drain", 32'(pulses), 32'd1);
        chk("SPART_pc 0x100", bus.SPART_pc, 32'h100);

        // Minimum-latency switch, second SWITCH during DRAIN rejected
        wr(32'h4, 32'h0000_0200);
        wr(32'h4, 32'h0000_0300);
        chk("pulse at N+2", 32'(bus.switch_program), 32'd1);
        chk("SPART_pc 0x200", bus.SPART_pc, 32'h200);
        chk("rejected switch flagged", 32'(bus.ovf_err), 32'd1);
        idle(2);
        chk("SPART_pc held", bus.SPART_pc, 32'h200);
        wr(32'h8, 32'h0000_0001);

        // Flush releases a pending DRAIN
        bus.tx_ready = 1'b0;
        wr(32'h0, 32'hB1);
        wr(32'h0, 32'hB2);
        wr(32'h4, 32'h0000_0400);
        wr(32'h8, 32'h0000_0002);
        idle(3);
        chk("flush then fire", bus.SPART_pc, 32'h400);

        // Reset mid-DRAIN aborts the switch and discards the reset-cycle write
        wr(32'h0, 32'hC1);
        wr(32'h4, 32'h0000_0500);
        rst = 1'b1;
        wr(32'h0, 32'hC2);
        rst = 1'b0;
        chk("rst fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("rst SPART_pc", bus.SPART_pc, 32'h0);
        chk("rst ovf_err", 32'(bus.ovf_err), 32'd0);
        bus.tx_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.switch_program) pulses++;
        end
        chk("no pulse after reset", 32'(pulses), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spart_wr_responder.md
SPART_WR_RESPONDER -- requirements
Module: spart_wr_responder

Interface
REQ-001 Parameters: FIFO_DEPTH, default 8, TX byte FIFO entries (power of two); CNT_W, default 4, width of fifo_count (log2(FIFO_DEPTH)+1).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 spart_wrt_en  input  1  CPU store strobe, one write per cycle when high.
REQ-005 spart_wrt_add  input  32  CPU store address, full 32-bit compare.
REQ-006 spart_wrt_data  input  32  CPU store data.
REQ-007 tx_data  output  8  byte at FIFO head.
REQ-008 tx_valid  output  1  FIFO non-empty.
REQ-009 tx_ready  input  1  downstream serializer accepts tx_data this cycle.
REQ-010 switch_program  output  1  one-cycle request to CPU to restart at SPART_pc.
REQ-011 SPART_pc  output  32  target PC for the CPU, held stable between switches.
REQ-012 ovf_err  output  1  sticky error: dropped TX byte or rejected switch request.
REQ-013 fifo_count  output  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-014 Address map: 0x00000000 TX_DATA; 0x00000004 SWITCH; 0x00000008 CTRL; writes to any other address have no effect.
REQ-015 TX_DATA write: spart_wrt_data[7:0] is pushed to the FIFO tail; bits [31:8] are ignored.
REQ-016 FIFO is first-word-fall-through: tx_data = head entry and tx_valid = (fifo_count != 0), both driven from registers or the head entry with no input-to-output combinational path.
REQ-017 Pop occurs on the cycle in which tx_valid && tx_ready; fifo_count reflects the pop on the next cycle.
REQ-018 Push into a full FIFO without a simultaneous pop drops the byte, leaves the FIFO unchanged, and sets ovf_err on the next cycle.
REQ-019 Push into a full FIFO with a simultaneous pop is accepted; fifo_count stays at FIFO_DEPTH.
REQ-020 Push into an empty FIFO: tx_valid rises on the next cycle; a same-cycle pop is impossible because tx_valid is 0.
REQ-021 Read and write pointers wrap modulo FIFO_DEPTH; byte order is preserved across wrap-around.
REQ-022 Switch FSM states: IDLE, DRAIN, FIRE.
REQ-023 IDLE + SWITCH write: latch spart_wrt_data into pend_pc; go to DRAIN.
REQ-024 DRAIN: wait until fifo_count == 0 and no push is in progress this cycle, then go to FIRE; TX_DATA writes remain accepted while in DRAIN.
REQ-025 FIRE: SPART_pc <= pend_pc and switch_program = 1 for exactly one cycle; next state IDLE.
REQ-026 Switch handshake timing: SPART_pc is updated on the same edge that raises switch_program, and SPART_pc holds its value after switch_program falls.
REQ-027 SWITCH write in DRAIN or FIRE is ignored (pend_pc unchanged) and sets ovf_err.
REQ-028 Minimum latency: SWITCH write at cycle N with an empty FIFO gives DRAIN at N+1 and switch_program high at N+2.
REQ-029 CTRL write, bit0 = 1: clear ovf_err; an error event in the same cycle takes priority and ovf_err stays 1.
REQ-030 CTRL write, bit1 = 1: flush the FIFO (pointers and count to 0); a same-cycle pop is suppressed. A pending DRAIN then proceeds to FIRE.
REQ-031 CTRL write: all other bits are ignored.
REQ-032 At most one write is decoded per cycle, since the address is unique.

Reset
REQ-033 With rst high at a posedge: FIFO empty; fifo_count = 0; tx_valid = 0; switch_program = 0; SPART_pc = 0x00000000; pend_pc = 0; ovf_err = 0; state IDLE.
REQ-034 tx_data after reset is don't-care while tx_valid = 0.
REQ-035 Reset asserted mid-DRAIN or mid-FIRE aborts the switch: no switch_program pulse is issued afterward, and writes in the reset cycle are discarded.

Verification
REQ-036 Push 0x41, 0x42, 0x43 with tx_ready = 1 held -> tx_data sequence 0x41, 0x42, 0x43 on consecutive tx_valid cycles; fifo_count returns to 0.
REQ-037 tx_ready = 0, push 9 bytes 0x00..0x08 -> fifo_count = 8, ovf_err = 1, 0x08 absent; drain yields 0x00..0x07; CTRL write 0x1 then clears ovf_err.
REQ-038 FIFO full, push 0x55 while tx_ready = 1 -> accepted, count stays 8, 0x55 emerged last; run 20 pushes/pops to cover pointer wrap.
REQ-039 Three bytes queued, tx_ready = 0, SWITCH write 0x00000100 -> no pulse; raise tx_ready -> one-cycle switch_program with SPART_pc = 0x00000100, asserted only after the last byte pops.
REQ-040 SWITCH write 0x200 with empty FIFO -> pulse two cycles later; second SWITCH write during DRAIN sets ovf_err and SPART_pc = 0x200.
REQ-041 rst asserted during DRAIN -> all REQ-033 values, and no pulse afterward.
